// File: rtl/aurora_bus_monitor_if.sv
// Channel-side and debug-side signal bundle of the Aurora bus monitor.
// The monitor itself sits on the slave modport; the channel tap / ILA side uses master.
interface aurora_bus_monitor_if #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 2,
    parameter int FLAG_W = 10,
    parameter int CNT_W  = 16
);
    logic [NUM_CH-1:0]        ch_vld;
    logic [NUM_CH*DATA_W-1:0] ch_dat;
    logic [FLAG_W-1:0]        flags;

    logic [NUM_CH-1:0]        dbg_vld;
    logic [NUM_CH*DATA_W-1:0] dbg_dat;
    logic [FLAG_W-1:0]        dbg_flags;
    logic [NUM_CH-1:0]        dbg_dup;
    logic                     dbg_trig;
    logic [NUM_CH-1:0]        dup_sticky;
    logic [NUM_CH*CNT_W-1:0]  dup_cnt;
    logic [NUM_CH*CNT_W-1:0]  word_cnt;

    modport master (
        output ch_vld, ch_dat, flags,
        input  dbg_vld, dbg_dat, dbg_flags, dbg_dup, dbg_trig,
        input  dup_sticky, dup_cnt, word_cnt
    );

    modport slave (
        input  ch_vld, ch_dat, flags,
        output dbg_vld, dbg_dat, dbg_flags, dbg_dup, dbg_trig,
        output dup_sticky, dup_cnt, word_cnt
    );
endinterface

// File: rtl/aurora_bus_monitor.sv
// Aurora bus debug tap: per-channel back-to-back duplicate detection with counters,
// and a fixed-latency debug bus (data, flags, dup, trigger) for the ILA.
module aurora_bus_monitor #(
    parameter int DATA_W     = 32,
    parameter int NUM_CH     = 2,
    parameter int FLAG_W     = 10,
    parameter int PIPE_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    aurora_bus_monitor_if.slave bus
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [NUM_CH-1:0]        s1_vld_q;
    logic [NUM_CH*DATA_W-1:0] s1_dat_q;
    logic [FLAG_W-1:0]        s1_flags_q;

    logic [NUM_CH*DATA_W-1:0] last_dat_q, last_dat_d;
    logic [NUM_CH-1:0]        hist_vld_q, hist_vld_d;
    logic [NUM_CH-1:0]        dup_raw;

    logic [NUM_CH-1:0]        vld_pipe_q   [2:PIPE_DEPTH];
    logic [NUM_CH*DATA_W-1:0] dat_pipe_q   [2:PIPE_DEPTH];
    logic [FLAG_W-1:0]        flags_pipe_q [2:PIPE_DEPTH];
    logic [NUM_CH-1:0]        dup_pipe_q   [2:PIPE_DEPTH];
    logic [NUM_CH-1:0]        dup_last_in;
    logic                     trig_q;

    logic [NUM_CH*CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [NUM_CH*CNT_W-1:0]  dup_cnt_q, dup_cnt_d;
    logic [NUM_CH-1:0]        sticky_q, sticky_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q   <= '0;
            s1_dat_q   <= '0;
            s1_flags_q <= '0;
        end else begin
            s1_vld_q   <= bus.ch_vld;
            s1_dat_q   <= bus.ch_dat;
            s1_flags_q <= bus.flags;
        end
    end

    // Compare against the history before it is overwritten by this same word;
    // clr wins over a load so the word after a clear can never match.
    always_comb begin
        last_dat_d = last_dat_q;
        hist_vld_d = hist_vld_q;
        dup_raw    = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            dup_raw[n] = s1_vld_q[n] & hist_vld_q[n] &
                         (s1_dat_q[n*DATA_W +: DATA_W] == last_dat_q[n*DATA_W +: DATA_W]);
            if (clr) begin
                hist_vld_d[n] = 1'b0;
            end else if (s1_vld_q[n]) begin
                hist_vld_d[n]                  = 1'b1;
                last_dat_d[n*DATA_W +: DATA_W] = s1_dat_q[n*DATA_W +: DATA_W];
            end
        end
    end

    // The trigger is registered alongside the last delay stage, so it needs the dup
    // vector that is about to enter that stage.
    if (PIPE_DEPTH == 2) begin : g_short_pipe
        assign dup_last_in = dup_raw;
    end else begin : g_long_pipe
        assign dup_last_in = dup_pipe_q[PIPE_DEPTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 2; k <= PIPE_DEPTH; k++) begin
                vld_pipe_q[k]   <= '0;
                dat_pipe_q[k]   <= '0;
                flags_pipe_q[k] <= '0;
                dup_pipe_q[k]   <= '0;
            end
            trig_q <= 1'b0;
        end else begin
            vld_pipe_q[2]   <= s1_vld_q;
            dat_pipe_q[2]   <= s1_dat_q;
            flags_pipe_q[2] <= s1_flags_q;
            dup_pipe_q[2]   <= dup_raw;
            for (int k = 3; k <= PIPE_DEPTH; k++) begin
                vld_pipe_q[k]   <= vld_pipe_q[k-1];
                dat_pipe_q[k]   <= dat_pipe_q[k-1];
                flags_pipe_q[k] <= flags_pipe_q[k-1];
                dup_pipe_q[k]   <= dup_pipe_q[k-1];
            end
            trig_q <= |dup_last_in;
        end
    end

    // Statistics follow stage 2 rather than the debug output; word counts wrap,
    // duplicate counts stick at all-ones.
    always_comb begin
        word_cnt_d = word_cnt_q;
        dup_cnt_d  = dup_cnt_q;
        sticky_d   = sticky_q;
        if (clr) begin
            word_cnt_d = '0;
            dup_cnt_d  = '0;
            sticky_d   = '0;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (vld_pipe_q[2][n]) begin
                    word_cnt_d[n*CNT_W +: CNT_W] = word_cnt_q[n*CNT_W +: CNT_W] + CntOne;
                end
                if (dup_pipe_q[2][n]) begin
                    sticky_d[n] = 1'b1;
                    if (dup_cnt_q[n*CNT_W +: CNT_W] != '1) begin
                        dup_cnt_d[n*CNT_W +: CNT_W] = dup_cnt_q[n*CNT_W +: CNT_W] + CntOne;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_dat_q <= '0;
            hist_vld_q <= '0;
            word_cnt_q <= '0;
            dup_cnt_q  <= '0;
            sticky_q   <= '0;
        end else begin
            last_dat_q <= last_dat_d;
            hist_vld_q <= hist_vld_d;
            word_cnt_q <= word_cnt_d;
            dup_cnt_q  <= dup_cnt_d;
            sticky_q   <= sticky_d;
        end
    end

    assign bus.dbg_vld    = vld_pipe_q[PIPE_DEPTH];
    assign bus.dbg_dat    = dat_pipe_q[PIPE_DEPTH];
    assign bus.dbg_flags  = flags_pipe_q[PIPE_DEPTH];
    assign bus.dbg_dup    = dup_pipe_q[PIPE_DEPTH];
    assign bus.dbg_trig   = trig_q;
    assign bus.dup_sticky = sticky_q;
    assign bus.dup_cnt    = dup_cnt_q;
    assign bus.word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_aurora_bus_monitor.sv
// Three monitor configurations driven in lock-step by the same stimulus and compared
// every cycle against a word-level reference model, plus directed counter checks.
module tb_aurora_bus_monitor;

    localparam int DATA_W = 32;
    localparam int NUM_CH = 2;
    localparam int FLAG_W = 10;
    localparam int MAXC   = 2048;
    localparam int NINST  = 3;
    localparam int PD_A = 4,  CW_A = 4;
    localparam int PD_B = 2,  CW_B = 16;
    localparam int PD_C = 16, CW_C = 16;

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     clear;
    logic [NUM_CH-1:0]        chVld;
    logic [NUM_CH*DATA_W-1:0] chDat;
    logic [FLAG_W-1:0]        chFlags;

    int compareCount  = 0;
    int mismatchCount = 0;
    int cycle         = 0;
    int lastRst       = -1;

    // Reference model state: every presented word is kept, indexed by the edge that sampled it.
    logic                     inVld   [MAXC][NUM_CH];
    logic [DATA_W-1:0]        inDat   [MAXC][NUM_CH];
    logic [FLAG_W-1:0]        inFlags [MAXC];
    logic                     inRst   [MAXC];
    logic                     inClr   [MAXC];
    logic                     wordDup [MAXC][NUM_CH];
    logic                     histVld [NUM_CH];
    logic [DATA_W-1:0]        histDat [NUM_CH];
    int                       wordCount [NINST][NUM_CH];
    int                       dupCount  [NINST][NUM_CH];
    logic                     stickyExp [NINST][NUM_CH];

    aurora_bus_monitor_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .FLAG_W(FLAG_W), .CNT_W(CW_A)) busA ();
    aurora_bus_monitor_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .FLAG_W(FLAG_W), .CNT_W(CW_B)) busB ();
    aurora_bus_monitor_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .FLAG_W(FLAG_W), .CNT_W(CW_C)) busC ();

    assign busA.ch_vld = chVld;  assign busA.ch_dat = chDat;  assign busA.flags = chFlags;
    assign busB.ch_vld = chVld;  assign busB.ch_dat = chDat;  assign busB.flags = chFlags;
    assign busC.ch_vld = chVld;  assign busC.ch_dat = chDat;  assign busC.flags = chFlags;

    aurora_bus_monitor #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .FLAG_W(FLAG_W),
                         .PIPE_DEPTH(PD_A), .CNT_W(CW_A))
        dutA (.clk(clock), .rst(reset), .clr(clear), .bus(busA.slave));
    aurora_bus_monitor #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .FLAG_W(FLAG_W),
                         .PIPE_DEPTH(PD_B), .CNT_W(CW_B))
        dutB (.clk(clock), .rst(reset), .clr(clear), .bus(busB.slave));
    aurora_bus_monitor #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .FLAG_W(FLAG_W),
                         .PIPE_DEPTH(PD_C), .CNT_W(CW_C))
        dutC (.clk(clock), .rst(reset), .clr(clear), .bus(busC.slave));

    always #5 clock = ~clock;

    function automatic int cntWidthOf(input int i);
        case (i)
            0:       return CW_A;
            1:       return CW_B;
            default: return CW_C;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL cycle %0d %s: observed %h, expected %h", cycle, tag, observed, expected);
        end
    endtask

    // A word sampled at edge w is judged against the last surviving valid word of its channel
    // when it leaves stage 1 (edge w+1), and is counted when it leaves stage 2 (edge w+2).
    task automatic modelEdge();
        int m;
        int w;
        m = cycle;
        if (m >= 1) begin
            w = m - 1;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                logic live;
                live = (w > lastRst) && inVld[w][ch];
                wordDup[w][ch] = live && histVld[ch] && (inDat[w][ch] == histDat[ch]);
                if (inRst[m] || inClr[m]) begin
                    histVld[ch] = 1'b0;
                end else if (live) begin
                    histVld[ch] = 1'b1;
                    histDat[ch] = inDat[w][ch];
                end
            end
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) histVld[ch] = 1'b0;
        end
        w = m - 2;
        for (int i = 0; i < NINST; i++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (inRst[m] || inClr[m]) begin
                    wordCount[i][ch] = 0;
                    dupCount[i][ch]  = 0;
                    stickyExp[i][ch] = 1'b0;
                end else if (w >= 0 && w > lastRst) begin
                    if (inVld[w][ch]) wordCount[i][ch] = (wordCount[i][ch] + 1) % (1 << cntWidthOf(i));
                    if (wordDup[w][ch]) begin
                        stickyExp[i][ch] = 1'b1;
                        if (dupCount[i][ch] < (1 << cntWidthOf(i)) - 1) dupCount[i][ch]++;
                    end
                end
            end
        end
        if (inRst[m]) lastRst = m;
    endtask

    task automatic compareInstance(
        input string name, input int i, input int pd,
        input logic [NUM_CH-1:0] oVld, input logic [NUM_CH*DATA_W-1:0] oDat,
        input logic [FLAG_W-1:0] oFlags, input logic [NUM_CH-1:0] oDup, input logic oTrig,
        input logic [NUM_CH-1:0] oSticky,
        input logic [31:0] oDup0, input logic [31:0] oDup1,
        input logic [31:0] oWord0, input logic [31:0] oWord1);
        logic [NUM_CH-1:0]        eVld, eDup, eSticky;
        logic [NUM_CH*DATA_W-1:0] eDat;
        logic [FLAG_W-1:0]        eFlags;
        int w;
        eVld = '0; eDup = '0; eDat = '0; eFlags = '0;
        w = cycle - pd + 1;
        if (w >= 0 && w > lastRst) begin
            eFlags = inFlags[w];
            for (int ch = 0; ch < NUM_CH; ch++) begin
                eVld[ch]                   = inVld[w][ch];
                eDup[ch]                   = wordDup[w][ch];
                eDat[ch*DATA_W +: DATA_W]  = inDat[w][ch];
            end
        end
        for (int ch = 0; ch < NUM_CH; ch++) eSticky[ch] = stickyExp[i][ch];
        checkOutput({name, ".dbg_vld"},    64'(oVld),    64'(eVld));
        checkOutput({name, ".dbg_dat"},    64'(oDat),    64'(eDat));
        checkOutput({name, ".dbg_flags"},  64'(oFlags),  64'(eFlags));
        checkOutput({name, ".dbg_dup"},    64'(oDup),    64'(eDup));
        checkOutput({name, ".dbg_trig"},   64'(oTrig),   64'(|eDup));
        checkOutput({name, ".dup_sticky"}, 64'(oSticky), 64'(eSticky));
        checkOutput({name, ".dup_cnt0"},   64'(oDup0),   64'(dupCount[i][0]));
        checkOutput({name, ".dup_cnt1"},   64'(oDup1),   64'(dupCount[i][1]));
        checkOutput({name, ".word_cnt0"},  64'(oWord0),  64'(wordCount[i][0]));
        checkOutput({name, ".word_cnt1"},  64'(oWord1),  64'(wordCount[i][1]));
    endtask

    task automatic compareAll();
        compareInstance("A", 0, PD_A, busA.dbg_vld, busA.dbg_dat, busA.dbg_flags, busA.dbg_dup,
                        busA.dbg_trig, busA.dup_sticky,
                        32'(busA.dup_cnt[CW_A-1:0]),  32'(busA.dup_cnt[2*CW_A-1:CW_A]),
                        32'(busA.word_cnt[CW_A-1:0]), 32'(busA.word_cnt[2*CW_A-1:CW_A]));
        compareInstance("B", 1, PD_B, busB.dbg_vld, busB.dbg_dat, busB.dbg_flags, busB.dbg_dup,
                        busB.dbg_trig, busB.dup_sticky,
                        32'(busB.dup_cnt[CW_B-1:0]),  32'(busB.dup_cnt[2*CW_B-1:CW_B]),
                        32'(busB.word_cnt[CW_B-1:0]), 32'(busB.word_cnt[2*CW_B-1:CW_B]));
        compareInstance("C", 2, PD_C, busC.dbg_vld, busC.dbg_dat, busC.dbg_flags, busC.dbg_dup,
                        busC.dbg_trig, busC.dup_sticky,
                        32'(busC.dup_cnt[CW_C-1:0]),  32'(busC.dup_cnt[2*CW_C-1:CW_C]),
                        32'(busC.word_cnt[CW_C-1:0]), 32'(busC.word_cnt[2*CW_C-1:CW_C]));
    endtask

    // Drive one cycle, advance the model on the sampling edge, compare on the falling edge.
    task automatic applyStimulus(input logic [NUM_CH-1:0] v, input logic [NUM_CH*DATA_W-1:0] d,
                                 input logic c, input logic r);
        logic [FLAG_W-1:0] f;
        if (cycle >= MAXC) begin
            $display("[TB] FAIL cycle %0d bench.capacity: observed %0d, expected below %0d", cycle, cycle, MAXC);
            $fatal(1, "[TB] model history exhausted");
        end
        f       = FLAG_W'($urandom);
        chVld   = v;
        chDat   = d;
        chFlags = f;
        clear   = c;
        reset   = r;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            inVld[cycle][ch] = v[ch];
            inDat[cycle][ch] = d[ch*DATA_W +: DATA_W];
        end
        inFlags[cycle] = f;
        inRst[cycle]   = r;
        inClr[cycle]   = c;
        @(posedge clock);
        modelEdge();
        @(negedge clock);
        compareAll();
        cycle++;
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus('0, {$urandom, $urandom}, 1'b0, 1'b0);
    endtask

    task automatic ch0Word(input logic [DATA_W-1:0] word);
        applyStimulus(2'b01, {$urandom, word}, 1'b0, 1'b0);
    endtask

    initial begin
        logic [DATA_W-1:0] pool [3];
        logic [NUM_CH-1:0] v;
        logic [NUM_CH*DATA_W-1:0] d;
        pool[0] = 32'h0000_1234;
        pool[1] = 32'hA5A5_0001;
        pool[2] = 32'h0000_0000;
        for (int ch = 0; ch < NUM_CH; ch++) histVld[ch] = 1'b0;

        for (int k = 0; k < 3; k++) applyStimulus(NUM_CH'($urandom), {$urandom, $urandom}, 1'($urandom), 1'b1);
        ch0Word(32'h0000_0001);
        idleCycles(6);

        applyStimulus('0, {$urandom, $urandom}, 1'b1, 1'b0);
        ch0Word(32'hA5A5_0001);
        ch0Word(32'hA5A5_0001);
        ch0Word(32'hA5A5_0002);
        idleCycles(6);
        checkOutput("b2b.dup_cnt0",  64'(busA.dup_cnt[CW_A-1:0]),  64'd1);
        checkOutput("b2b.word_cnt0", 64'(busA.word_cnt[CW_A-1:0]), 64'd3);
        checkOutput("b2b.sticky0",   64'(busA.dup_sticky[0]),      64'd1);

        applyStimulus('0, {$urandom, $urandom}, 1'b1, 1'b0);
        applyStimulus(2'b11, {32'h0000_1234, 32'h0000_1234}, 1'b0, 1'b0);
        idleCycles(5);
        applyStimulus(2'b10, {32'h0000_1234, 32'h0000_1234}, 1'b0, 1'b0);
        idleCycles(6);
        checkOutput("gap.dup_cnt1", 64'(busA.dup_cnt[2*CW_A-1:CW_A]), 64'd1);
        checkOutput("gap.dup_cnt0", 64'(busA.dup_cnt[CW_A-1:0]),      64'd0);

        applyStimulus('0, {$urandom, $urandom}, 1'b1, 1'b0);
        ch0Word(32'h0BAD_F00D);
        ch0Word(32'h0BAD_F00D);
        idleCycles(1);
        applyStimulus('0, {$urandom, $urandom}, 1'b1, 1'b0);
        ch0Word(32'h0BAD_F00D);
        checkOutput("clr.dbg_dup0", 64'(busA.dbg_dup[0]), 64'd1);
        idleCycles(6);
        checkOutput("clr.dup_cnt0",  64'(busA.dup_cnt[CW_A-1:0]),  64'd0);
        checkOutput("clr.sticky0",   64'(busA.dup_sticky[0]),      64'd0);
        checkOutput("clr.word_cnt0", 64'(busA.word_cnt[CW_A-1:0]), 64'd1);

        applyStimulus('0, {$urandom, $urandom}, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) ch0Word(32'h5A5A_5A5A);
        idleCycles(4);
        checkOutput("sat.dup_cntA",  64'(busA.dup_cnt[CW_A-1:0]),  64'd15);
        checkOutput("sat.word_cntA", 64'(busA.word_cnt[CW_A-1:0]), 64'd4);
        checkOutput("sat.dup_cntB",  64'(busB.dup_cnt[CW_B-1:0]),  64'd19);
        checkOutput("sat.word_cntB", 64'(busB.word_cnt[CW_B-1:0]), 64'd20);

        for (int k = 0; k < 1500; k++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                v[ch] = ($urandom_range(0, 9) < 6);
                d[ch*DATA_W +: DATA_W] = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 2)];
            end
            applyStimulus(v, d, ($urandom_range(0, 49) == 0), ($urandom_range(0, 199) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
